// File: rtl/alu16_sequencer_pkg.sv
// Shared ALU opcode type and Z80 F-register bit positions used by the sequencer and the 8-bit ALU.
package alu16_sequencer_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    ADC = 3'd1,
    SUB = 3'd2,
    SBC = 3'd3,
    INC = 3'd4,
    DEC = 3'd5
  } alu_op;

  localparam int F_S  = 7;
  localparam int F_Z  = 6;
  localparam int F_Y  = 5;
  localparam int F_H  = 4;
  localparam int F_X  = 3;
  localparam int F_PV = 2;
  localparam int F_N  = 1;
  localparam int F_C  = 0;

  // Anything the sequencer does not recognise as a 16-bit operation runs as ADD.
  function automatic alu_op norm_op(input alu_op o);
    case (o)
      ADC, SBC, INC, DEC: return o;
      default:            return ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational Z80-style byte ALU: add/subtract with optional carry-in, full F status output.
module alu
  import alu16_sequencer_pkg::*;
#(
  parameter int alu_width = 8
) (
  input  logic [alu_width-1:0] a_i,
  input  logic [alu_width-1:0] b_i,
  input  alu_op                op_i,
  input  logic                 carry_i,
  input  logic                 en_i,
  output logic [alu_width-1:0] out_o,
  output logic [7:0]           status_o
);

  logic                 sub;
  logic                 cin;
  logic [alu_width:0]   full;
  logic [4:0]           half;
  logic [alu_width-1:0] r;
  logic                 ov;

  always_comb begin
    sub  = (op_i == SUB) || (op_i == SBC);
    cin  = ((op_i == ADC) || (op_i == SBC)) ? carry_i : 1'b0;
    if (sub) begin
      full = {1'b0, a_i} - {1'b0, b_i} - {{alu_width{1'b0}}, cin};
      half = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'b0, cin};
    end else begin
      full = {1'b0, a_i} + {1'b0, b_i} + {{alu_width{1'b0}}, cin};
      half = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0, cin};
    end
    r  = full[alu_width-1:0];
    // Signed overflow: operands agree (add) or differ (sub) in sign and result sign flips.
    ov = sub ? ((a_i[alu_width-1] != b_i[alu_width-1]) && (r[alu_width-1] != a_i[alu_width-1]))
             : ((a_i[alu_width-1] == b_i[alu_width-1]) && (r[alu_width-1] != a_i[alu_width-1]));
    out_o    = '0;
    status_o = '0;
    if (en_i) begin
      out_o    = r;
      status_o = {r[alu_width-1], (r == '0), r[5], half[4], r[3], ov, sub, full[alu_width]};
    end
  end

endmodule

// File: rtl/alu16_sequencer.sv
// Runs one 16-bit add/subtract as two passes (low byte, then high byte) through an external 8-bit ALU.
module alu16_sequencer
  import alu16_sequencer_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  alu_op                 op,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic [7:0]            flags_in,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] result,
  output logic [7:0]            flags_out,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output alu_op                 alu_opcode,
  output logic                  alu_carry_in,
  output logic                  alu_enable,
  input  logic [7:0]            alu_out,
  input  logic [7:0]            alu_status
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t                state_q;
  alu_op                 op_q;
  logic [7:0]            ahi_q, bhi_q, fin_q, lo_q;
  logic                  busy_q, done_q, cin_q, en_q;
  logic [data_width-1:0] result_q;
  logic [7:0]            flags_q, alu_a_q, alu_b_q;
  alu_op                 opc_q;

  alu_op                 op_n, lo_opc;
  logic [data_width-1:0] b_eff, res_d;
  logic                  lo_cin, sub_q;
  logic [7:0]            flags_d;
  logic                  unused_status;

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign flags_out    = flags_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = opc_q;
  assign alu_carry_in = cin_q;
  assign alu_enable   = en_q;
  assign unused_status = ^{alu_status[F_S], alu_status[F_Z], alu_status[F_N]};

  always_comb begin
    op_n   = norm_op(op);
    b_eff  = ((op_n == INC) || (op_n == DEC)) ? 16'h0001 : b;
    lo_cin = ((op_n == ADC) || (op_n == SBC)) ? flags_in[F_C] : 1'b0;
    case (op_n)
      ADC:     lo_opc = ADC;
      SBC:     lo_opc = SBC;
      DEC:     lo_opc = SUB;
      default: lo_opc = ADD;
    endcase
    sub_q = (op_q == SBC) || (op_q == DEC);
    res_d = {alu_out, lo_q};
  end

  // Final F: ADD keeps S/Z/PV from the caller, ADC/SBC compute all from the 16-bit result.
  always_comb begin
    flags_d = fin_q;
    case (op_q)
      ADC, SBC: begin
        flags_d[F_S]  = res_d[15];
        flags_d[F_Z]  = (res_d == '0);
        flags_d[F_Y]  = res_d[13];
        flags_d[F_H]  = alu_status[F_H];
        flags_d[F_X]  = res_d[11];
        flags_d[F_PV] = alu_status[F_PV];
        flags_d[F_N]  = (op_q == SBC);
        flags_d[F_C]  = alu_status[F_C];
      end
      INC, DEC: flags_d = fin_q;
      default: begin
        flags_d[F_Y] = alu_status[F_Y];
        flags_d[F_H] = alu_status[F_H];
        flags_d[F_X] = alu_status[F_X];
        flags_d[F_N] = 1'b0;
        flags_d[F_C] = alu_status[F_C];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= ADD;
      ahi_q    <= '0;
      bhi_q    <= '0;
      fin_q    <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      opc_q    <= ADD;
      cin_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op_n;
            ahi_q   <= a[15:8];
            bhi_q   <= b_eff[15:8];
            fin_q   <= flags_in;
            alu_a_q <= a[7:0];
            alu_b_q <= b_eff[7:0];
            opc_q   <= lo_opc;
            cin_q   <= lo_cin;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LOW;
          end
        end
        S_LOW: begin
          lo_q    <= alu_out;
          alu_a_q <= ahi_q;
          alu_b_q <= bhi_q;
          opc_q   <= sub_q ? SBC : ADC;
          cin_q   <= alu_status[F_C];
          state_q <= S_HIGH;
        end
        S_HIGH: begin
          result_q <= res_d;
          flags_q  <= flags_d;
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          opc_q    <= ADD;
          cin_q    <= 1'b0;
          en_q     <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Scoreboard bench for alu16_sequencer driving an 8-bit alu: directed vectors, abort on reset, ignored restarts.
module tb_alu16_sequencer;
  import alu16_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  alu_op       op = ADD;
  logic [15:0] a = '0, b = '0;
  logic [7:0]  flags_in = '0;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  flags_out;
  logic [7:0]  alu_a, alu_b, alu_out, alu_status;
  alu_op       alu_opcode;
  logic        alu_carry_in, alu_enable;

  typedef struct {
    logic [15:0] r;
    logic [7:0]  f;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  alu16_sequencer #(.data_width(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flags_in(flags_in),
    .busy(busy), .done(done), .result(result), .flags_out(flags_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_carry_in(alu_carry_in),
    .alu_enable(alu_enable), .alu_out(alu_out), .alu_status(alu_status)
  );

  alu #(.alu_width(8)) u_alu (
    .a_i(alu_a), .b_i(alu_b), .op_i(alu_opcode), .carry_i(alu_carry_in), .en_i(alu_enable),
    .out_o(alu_out), .status_o(alu_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 result=%0h", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {16'h0, result}, {16'h0, e.r});
        chk("flags_out", {24'h0, flags_out}, {24'h0, e.f});
        chk("done_latency", cyc, e.cyc);
      end
    end
  end

  task automatic run_op(input alu_op o, input logic [15:0] av, input logic [15:0] bv,
                        input logic [7:0] fv, input logic [15:0] er, input logic [7:0] ef,
                        input bit hold_start);
    exp_t e;
    int   n;
    @(negedge clk);
    op = o; a = av; b = bv; flags_in = fv; start = 1'b1;
    e.r = er; e.f = ef; e.cyc = cyc + 3;
    sb.push_back(e);
    @(negedge clk);
    start = hold_start;
    op = SBC; a = ~av; b = ~bv; flags_in = ~fv;
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=1 required=0");
    end
    chk("result_held", {16'h0, result}, {16'h0, er});
    chk("alu_idle", {31'h0, alu_enable}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_flags", {24'h0, flags_out}, 32'h0);
    chk("rst_alu_ab", {16'h0, alu_a, alu_b}, 32'h0);
    chk("rst_alu_ctl", {29'h0, alu_carry_in, alu_enable, (alu_opcode == ADD)}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    run_op(ADD, 16'h0007, 16'h0007, 8'h00, 16'h000E, 8'h00, 1'b0);
    run_op(ADD, 16'hABCD, 16'h0101, 8'hC4, 16'hACCE, 8'hEC, 1'b0);
    run_op(SBC, 16'hABCD, 16'hABCD, 8'h00, 16'h0000, 8'h42, 1'b0);
    run_op(SBC, 16'hABCD, 16'hABCE, 8'h00, 16'hFFFF, 8'hBB, 1'b0);
    run_op(ADC, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94, 1'b0);
    run_op(INC, 16'hFFFF, 16'h1234, 8'h5A, 16'h0000, 8'h5A, 1'b1);
    run_op(DEC, 16'h0000, 16'hABCD, 8'hA5, 16'hFFFF, 8'hA5, 1'b1);
    run_op(alu_op'(3'd7), 16'h1234, 16'h1111, 8'h00, 16'h2345, 8'h20, 1'b0);
    run_op(SUB, 16'h1234, 16'h1111, 8'h00, 16'h2345, 8'h20, 1'b0);
    run_op(ADD, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h11, 1'b0);
    run_op(ADC, 16'h0FFF, 16'h0001, 8'h00, 16'h1000, 8'h10, 1'b0);
    run_op(SBC, 16'h1000, 16'h0001, 8'h01, 16'h0FFE, 8'h1A, 1'b0);
    run_op(ADD, 16'h0001, 16'h0001, 8'h01, 16'h0002, 8'h00, 1'b0);

    // Abort in the high-byte cycle: nothing pushed, so any done pulse is flagged.
    @(negedge clk);
    op = ADD; a = 16'h1111; b = 16'h2222; flags_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("high_alu_en", {31'h0, alu_enable}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_result", {16'h0, result}, 32'h0);
    chk("abort_alu_en", {31'h0, alu_enable}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_op(ADD, 16'h0102, 16'h0304, 8'h00, 16'h0406, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu16_sequencer.md
ALU16_SEQUENCER -- requirements
Module: alu16_sequencer

Interface
REQ-001 The parameter data_width SHALL default to 16 and set the operand/result width; only 16 is supported.
REQ-002 The clock input clk (1 bit) SHALL be the single clock; all state updates on its rising edge.
REQ-003 The reset input rst (1 bit) SHALL be asynchronous and active-high.
REQ-004 Port start, input, 1 bit, SHALL request one 16-bit operation; sampled only in IDLE.
REQ-005 Port op, input, alu_op, SHALL select ADD, ADC, SBC, INC or DEC; any other value SHALL behave as ADD.
REQ-006 Ports a and b, inputs, 16 bits each, SHALL carry the operands.
REQ-007 Port flags_in, input, 8 bits, SHALL carry the current Z80 F register: S=7, Z=6, Y=5, H=4, X=3, P/V=2, N=1, C=0.
REQ-008 Ports busy (1 bit) and done (1 bit), outputs, SHALL report operation in progress and completion.
REQ-009 Ports result (16 bits) and flags_out (8 bits), outputs, SHALL carry the final value and new F.
REQ-010 The ALU-side outputs SHALL be: alu_a (8), alu_b (8), alu_opcode (alu_op), alu_carry_in (1), alu_enable (1).
REQ-011 The ALU-side inputs SHALL be: alu_out (8) and alu_status (8, same F bit layout).

Function
REQ-012 The FSM SHALL have states IDLE, LOW, HIGH, DONE: IDLE->LOW on start; LOW->HIGH; HIGH->DONE; DONE->IDLE, all unconditional except IDLE.
REQ-013 On start in IDLE, a, b, op, flags_in SHALL be latched; later input changes SHALL not affect the operation.
REQ-014 done SHALL be a one-cycle pulse in DONE, exactly 3 cycles after the start edge; busy SHALL be high in LOW, HIGH, DONE.
REQ-015 start while busy SHALL be ignored; start asserted in the DONE cycle SHALL be ignored; a new start is accepted one cycle after DONE.
REQ-016 In LOW, the low byte SHALL be driven: ADD/INC/DEC use ADD/SUB with carry 0; ADC uses ADC with latched C; SBC uses SBC with latched C.
REQ-017 INC SHALL use b_eff=0x0001 (ADD) and DEC b_eff=0x0001 (SUB), regardless of b.
REQ-018 In HIGH, the high byte SHALL use ADC (additions) or SBC (subtractions), with alu_carry_in = C bit of the registered low-byte alu_status.
REQ-019 alu_enable SHALL be high only in LOW and HIGH; alu_a/alu_b/alu_opcode/alu_carry_in SHALL be 0/ADD/0 otherwise.
REQ-020 result SHALL be {high alu_out, low alu_out}, registered, and held stable from DONE until the next start is accepted.
REQ-021 ADD flags: S, Z, P/V from latched flags_in; H, C, Y, X from high-byte alu_status/result bits; N=0.
REQ-022 ADC/SBC flags: S=result[15]; Z=(result==0) over 16 bits; H, P/V, C from high-byte alu_status; N=0 for ADC, 1 for SBC; Y=result[13], X=result[11].
REQ-023 INC/DEC flags_out SHALL equal latched flags_in (no flags affected).
REQ-024 Wrap-around SHALL be modulo 2^16 (0xFFFF+1=0x0000, 0x0000-1=0xFFFF).

Reset
REQ-025 rst SHALL force IDLE immediately, at any state including mid-operation, aborting without a done pulse.
REQ-026 On reset, busy, done, result, flags_out, alu_a, alu_b, alu_carry_in, alu_enable SHALL be 0 and alu_opcode ADD.

Structure
REQ-027 alu_op and the F-bit index constants SHALL live in the shared alu_op package; the FSM state enum SHALL be local.
REQ-028 The block SHALL drive an external 8-bit alu instance; the testbench SHALL instantiate alu #(.alu_width(8)) as the sub-module.

Verification
REQ-029 ADD a=0x0007 b=0x0007 -> result 0x000E, C=0, N=0, done exactly 3 cycles after start.
REQ-030 ADD a=0xABCD b=0x0101 flags_in=0xC4 -> result 0xACCE, S/Z/P/V retained (bits 7,6,2 =1,1,1), C=0.
REQ-031 SBC a=0xABCD b=0xABCD C=0 -> 0x0000, Z=1, N=1, C=0; SBC a=0xABCD b=0xABCE C=0 -> 0xFFFF, S=1, C=1.
REQ-032 ADC a=0x7FFF b=0x0000 C=1 -> 0x8000, S=1, H=1, P/V=1, C=0.
REQ-033 INC 0xFFFF -> 0x0000 and DEC 0x0000 -> 0xFFFF, flags_out==flags_in; second start during busy ignored.
REQ-034 rst asserted during HIGH -> same-cycle IDLE, busy=0, result=0, no done pulse; next start completes normally.
